// File: rtl/controller_pkg.sv
// Shared constants for the breadboard controller front end: button indices,
// default debounce length and the released level of each button polarity.
package controller_pkg;

    localparam int BTN_LEFT   = 0;
    localparam int BTN_RIGHT  = 1;
    localparam int BTN_UP     = 2;
    localparam int BTN_DOWN   = 3;
    localparam int BTN_ATTACK = 4;
    localparam int BTN_SHIELD = 5;
    localparam int NUM_BTNS   = 6;

    // 10 ms at 100 MHz
    localparam int DEBOUNCE_DEFAULT = 1_000_000;

    localparam logic REL_ACTIVE_LOW  = 1'b1;
    localparam logic REL_ACTIVE_HIGH = 1'b0;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: synchroniser chain into clk, then a stability counter that
// only accepts a new level after DEBOUNCE_CYCLES consecutive differing samples.
module debounce_channel
    import controller_pkg::*;
#(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int   CNT_W           = 20,
    parameter logic RELEASED_LEVEL  = REL_ACTIVE_LOW
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic level_next
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_s;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;

    assign sync_s = sync_q[SYNC_STAGES-1];

    // NOTE: every flop here, sync chain included, is reset to the released level so
    // no phantom press can leak out of reset; state uses <= so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= {SYNC_STAGES{RELEASED_LEVEL}};
            cnt_q   <= '0;
            level_q <= RELEASED_LEVEL;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], raw};
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    // NOTE: defaults first so every path assigns cnt_d/level_d and no latch is inferred.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (sync_s == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            level_d = sync_s;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign level      = level_q;
    assign level_next = level_d;

endmodule

// File: rtl/controller_debouncer.sv
// Six debounced controller buttons plus registered press strobes for attack/shield.
// Direction outputs stay active-low, attack/shield stay active-high.
module controller_debouncer
    import controller_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic left_l_raw,
    input  logic right_l_raw,
    input  logic up_l_raw,
    input  logic down_l_raw,
    input  logic attack_raw,
    input  logic shield_raw,
    output logic left_l,
    output logic right_l,
    output logic up_l,
    output logic down_l,
    output logic attack,
    output logic shield,
    output logic attack_pulse,
    output logic shield_pulse
);

    logic [NUM_BTNS-1:0] raw_vec;
    logic [NUM_BTNS-1:0] level;
    logic [NUM_BTNS-1:0] level_next;
    logic                attack_pulse_q;
    logic                shield_pulse_q;
    logic                unused_dir_next;

    assign raw_vec[BTN_LEFT]   = left_l_raw;
    assign raw_vec[BTN_RIGHT]  = right_l_raw;
    assign raw_vec[BTN_UP]     = up_l_raw;
    assign raw_vec[BTN_DOWN]   = down_l_raw;
    assign raw_vec[BTN_ATTACK] = attack_raw;
    assign raw_vec[BTN_SHIELD] = shield_raw;

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_chan
        debounce_channel #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W),
            .RELEASED_LEVEL ((i >= BTN_ATTACK) ? REL_ACTIVE_HIGH : REL_ACTIVE_LOW)
        ) u_chan (
            .clk       (clk),
            .reset     (reset),
            .raw       (raw_vec[i]),
            .level     (level[i]),
            .level_next(level_next[i])
        );
    end

    // Strobes come from the next-state level so they line up with the first cycle
    // the debounced output reads 1, while still being driven straight from a flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            attack_pulse_q <= 1'b0;
            shield_pulse_q <= 1'b0;
        end else begin
            attack_pulse_q <= level_next[BTN_ATTACK] & ~level[BTN_ATTACK];
            shield_pulse_q <= level_next[BTN_SHIELD] & ~level[BTN_SHIELD];
        end
    end

    assign unused_dir_next = ^level_next[BTN_DOWN:BTN_LEFT];

    assign left_l       = level[BTN_LEFT];
    assign right_l      = level[BTN_RIGHT];
    assign up_l         = level[BTN_UP];
    assign down_l       = level[BTN_DOWN];
    assign attack       = level[BTN_ATTACK];
    assign shield       = level[BTN_SHIELD];
    assign attack_pulse = attack_pulse_q;
    assign shield_pulse = shield_pulse_q;

endmodule

// File: tb/tb_controller_debouncer.sv
// Directed bench for controller_debouncer with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
// Output vector: {shield_pulse, attack_pulse, shield, attack, down_l, up_l, right_l, left_l}.
module tb_controller_debouncer;

    logic clk = 1'b0;
    logic reset;
    logic left_l_raw, right_l_raw, up_l_raw, down_l_raw, attack_raw, shield_raw;
    logic left_l, right_l, up_l, down_l, attack, shield, attack_pulse, shield_pulse;
    logic [7:0] outs;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    controller_debouncer #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .left_l_raw  (left_l_raw),
        .right_l_raw (right_l_raw),
        .up_l_raw    (up_l_raw),
        .down_l_raw  (down_l_raw),
        .attack_raw  (attack_raw),
        .shield_raw  (shield_raw),
        .left_l      (left_l),
        .right_l     (right_l),
        .up_l        (up_l),
        .down_l      (down_l),
        .attack      (attack),
        .shield      (shield),
        .attack_pulse(attack_pulse),
        .shield_pulse(shield_pulse)
    );

    assign outs = {shield_pulse, attack_pulse, shield, attack, down_l, up_l, right_l, left_l};

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    // raw order: {shield, attack, down_l, up_l, right_l, left_l}
    task automatic set_raw(input logic [5:0] v);
        {shield_raw, attack_raw, down_l_raw, up_l_raw, right_l_raw, left_l_raw} = v;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick_hold(input string tag, input int n, input logic [7:0] exp);
        for (int i = 0; i < n; i++) begin
            tick(1);
            check(tag, outs, exp);
        end
    endtask

    initial begin
        logic [5:0] bounce;

        // 1: reset with everything pressed
        reset = 1'b1;
        set_raw(6'b110000);
        tick(1);
        check("t1_rst_first_edge", outs, 8'h0F);
        tick_hold("t1_rst_hold", 3, 8'h0F);
        reset = 1'b0;
        tick_hold("t1_post_rst_wait", 5, 8'h0F);
        tick(1);
        check("t1_assert", outs, 8'hF0);
        tick(1);
        check("t1_pulse_end", outs, 8'h30);
        set_raw(6'b001111);
        tick_hold("t1_release_wait", 5, 8'h30);
        tick(1);
        check("t1_released", outs, 8'h0F);
        tick(1);
        check("t1_no_release_pulse", outs, 8'h0F);

        // 2: attack press then release
        set_raw(6'b011111);
        tick_hold("t2_press_wait", 5, 8'h0F);
        tick(1);
        check("t2_attack_pulse", outs, 8'h5F);
        tick(1);
        check("t2_attack_held", outs, 8'h1F);
        set_raw(6'b001111);
        tick_hold("t2_release_wait", 5, 8'h1F);
        tick(1);
        check("t2_attack_release", outs, 8'h0F);
        tick_hold("t2_no_release_pulse", 2, 8'h0F);

        // 3: left bounces 1,1,0,0,1,1 then held 0
        bounce = 6'b110011;
        for (int i = 0; i < 6; i++) begin
            left_l_raw = bounce[i];
            tick(1);
            check("t3_bounce", outs, 8'h0F);
        end
        left_l_raw = 1'b0;
        tick_hold("t3_settle_wait", 5, 8'h0F);
        tick(1);
        check("t3_left_pressed", outs, 8'h0E);
        tick_hold("t3_left_stays", 3, 8'h0E);

        // 4: shield high for only 3 cycles
        set_raw(6'b101110);
        tick_hold("t4_glitch_high", 3, 8'h0E);
        set_raw(6'b001110);
        tick_hold("t4_glitch_after", 8, 8'h0E);

        // 5: all six toggle on the same edge
        set_raw(6'b110001);
        tick_hold("t5_wait", 5, 8'h0E);
        tick(1);
        check("t5_all_change", outs, 8'hF1);
        tick(1);
        check("t5_pulses_end", outs, 8'h31);

        // 6: reset in the middle of a down_l qualification
        set_raw(6'b001111);
        tick(6);
        check("t6_released", outs, 8'h0F);
        tick(1);
        set_raw(6'b000111);
        tick(4);
        check("t6_counting", outs, 8'h0F);
        check("t6_cnt_before_rst", 8'(u_dut.g_chan[3].u_chan.cnt_q), 8'd2);
        reset = 1'b1;
        tick(1);
        check("t6_in_reset", outs, 8'h0F);
        check("t6_cnt_cleared", 8'(u_dut.g_chan[3].u_chan.cnt_q), 8'd0);
        tick(1);
        check("t6_in_reset2", outs, 8'h0F);
        reset = 1'b0;
        tick_hold("t6_post_rst_wait", 5, 8'h0F);
        tick(1);
        check("t6_down_pressed", outs, 8'h07);
        tick(1);
        check("t6_down_held", outs, 8'h07);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
